// File: rtl/pulse_burst_sequencer.sv
// Scheduled test-pulse burst sequencer for the padiwa 16-channel LVDS pulse source.
// Software loads width/period/burst/mask/walk, then issues start; the block emits
// bursts on pulse_out and spare_out with optional per-pulse channel walking.
//
// Ports:
//   clk         133 MHz clock, all logic on posedge
//   reset_n     synchronous active-low reset
//   cfg_we      load cfg_* into the config registers (IDLE only)
//   cfg_width   pulse high time in clocks (0 is treated as 1)
//   cfg_period  rising-edge spacing in clocks (forced above width)
//   cfg_burst   pulses per burst, 0 = continuous until abort
//   cfg_mask    channel enable mask
//   cfg_walk    1 = one enabled channel per pulse, rotating upward
//   start       begin a burst (IDLE only)
//   abort       stop immediately from any state
//   busy        high while in HIGH/LOW
//   done        one-cycle pulse on normal completion of a finite burst
//   pulse_cnt   pulses since last start, saturating
//   pulse_out   registered channel pulses
//   spare_out   registered pulse timing, independent of mask
module pulse_burst_sequencer #(
  parameter int unsigned CNT_W      = 14,
  parameter logic [7:0]  DEF_WIDTH  = 8'd4,
  parameter int unsigned DEF_PERIOD = 12000,
  parameter logic [15:0] DEF_MASK   = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [7:0]       cfg_width,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [15:0]      cfg_burst,
  input  logic [15:0]      cfg_mask,
  input  logic             cfg_walk,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pulse_cnt,
  output logic [15:0]      pulse_out,
  output logic             spare_out
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StDone} state_e;

  state_e           state;
  logic [CNT_W-1:0] phase;
  logic [7:0]       width_r;
  logic [CNT_W-1:0] period_r;
  logic [15:0]      burst_r;
  logic [15:0]      mask_r;
  logic             walk_r;
  logic [3:0]       walk_ptr;

  logic             load;
  logic [7:0]       cfg_width_s;
  logic [CNT_W-1:0] cfg_width_ext;
  logic [CNT_W-1:0] cfg_period_s;
  logic [15:0]      eff_mask;
  logic             eff_walk;
  logic [CNT_W-1:0] width_ext;
  logic             hi_last;
  logic             lo_last;
  logic             burst_end;
  logic [3:0]       first_ptr;
  logic [3:0]       next_ptr;

  // Next set mask bit strictly above p, wrapping 15->0; returns p if none other is set.
  function automatic logic [3:0] next_set(input logic [15:0] m, input logic [3:0] p);
    logic [3:0] idx;
    logic       found;
    next_set = p;
    found    = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      idx = p + 4'(i);
      if (!found && m[idx]) begin
        next_set = idx;
        found    = 1'b1;
      end
    end
  endfunction

  always_comb begin
    load          = (state == StIdle) && cfg_we;
    cfg_width_s   = (cfg_width == 8'd0) ? 8'd1 : cfg_width;
    cfg_width_ext = {{(CNT_W-8){1'b0}}, cfg_width_s};
    cfg_period_s  = (cfg_period <= cfg_width_ext) ? cfg_width_ext + CNT_W'(1) : cfg_period;
    // A start in the same cycle as cfg_we uses the freshly written values.
    eff_mask      = load ? cfg_mask : mask_r;
    eff_walk      = load ? cfg_walk : walk_r;
    width_ext     = {{(CNT_W-8){1'b0}}, width_r};
    hi_last       = (phase == width_ext - CNT_W'(1));
    lo_last       = (phase == period_r - CNT_W'(1));
    burst_end     = (burst_r != 16'd0) && (pulse_cnt == burst_r);
    // Searching upward from 15 yields the lowest set bit.
    first_ptr     = next_set(eff_mask, 4'd15);
    next_ptr      = next_set(mask_r, walk_ptr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= StIdle;
      phase     <= '0;
      width_r   <= DEF_WIDTH;
      period_r  <= CNT_W'(DEF_PERIOD);
      burst_r   <= 16'd0;
      mask_r    <= DEF_MASK;
      walk_r    <= 1'b0;
      walk_ptr  <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= 16'd0;
      pulse_out <= 16'd0;
      spare_out <= 1'b0;
    end else begin
      if (load) begin
        width_r  <= cfg_width_s;
        period_r <= cfg_period_s;
        burst_r  <= cfg_burst;
        mask_r   <= cfg_mask;
        walk_r   <= cfg_walk;
      end
      if (abort) begin
        state     <= StIdle;
        busy      <= 1'b0;
        done      <= 1'b0;
        pulse_out <= 16'd0;
        spare_out <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (start) begin
              state     <= StHigh;
              phase     <= '0;
              pulse_cnt <= 16'd1;
              walk_ptr  <= first_ptr;
              busy      <= 1'b1;
              spare_out <= 1'b1;
              pulse_out <= eff_walk ? ((16'h1 << first_ptr) & eff_mask) : eff_mask;
            end
          end
          StHigh: begin
            phase <= phase + CNT_W'(1);
            if (hi_last) begin
              state     <= StLow;
              spare_out <= 1'b0;
              pulse_out <= 16'd0;
            end
          end
          StLow: begin
            if (lo_last) begin
              phase <= '0;
              if (burst_end) begin
                state <= StDone;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state     <= StHigh;
                walk_ptr  <= next_ptr;
                spare_out <= 1'b1;
                pulse_out <= walk_r ? ((16'h1 << next_ptr) & mask_r) : mask_r;
                if (pulse_cnt != 16'hFFFF) pulse_cnt <= pulse_cnt + 16'd1;
              end
            end else begin
              phase <= phase + CNT_W'(1);
            end
          end
          StDone: begin
            state <= StIdle;
            done  <= 1'b0;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
